dac_point_sequencer: RTL

Sequences (x, y) points into the two-channel MCP4922 DAC driver. Points arrive on a valid/ready stream, are buffered in a small FIFO, and each point is issued as an X write (axis 0) then a Y write (axis 1), followed by a programmable dwell. It sits between the vector list source and `mcp4922`, replacing the free-running counter stimulus in `vectorfpga`.

---
 rtl/vector_pkg.sv | 21 ++
 rtl/point_fifo.sv | 54 +++++
 rtl/dac_point_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared types for the vector display path: DAC sample width, point record
// and the point sequencer state encoding.
package vector_pkg;

  localparam int DAC_W = 12;

  typedef struct packed {
    logic [DAC_W-1:0] x;
    logic [DAC_W-1:0] y;
  } point_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_X,
    ST_HOLD_X,
    ST_SEND_Y,
    ST_HOLD_Y,
    ST_DWELL
  } seq_state_t;

endpackage

// File: rtl/point_fifo.sv
// Synchronous point FIFO: registered occupancy, no fall-through, so a word
// written on one edge is first readable in the following cycle.
module point_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged on the registered level, so a same-cycle pop never opens the input.
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dac_point_sequencer.sv
// Buffers (x, y) points and issues each one to the MCP4922 driver as an
// X write, a Y write and a programmable dwell.
module dac_point_sequencer
  import vector_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DWELL_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          pt_valid,
  output logic                          pt_ready,
  input  logic [DAC_W-1:0]              pt_x,
  input  logic [DAC_W-1:0]              pt_y,
  input  logic [DWELL_W-1:0]            dwell,
  output logic [DAC_W-1:0]              dac_value,
  output logic                          dac_axis,
  output logic                          dac_strobe,
  input  logic                          dac_ready,
  output logic                          busy,
  output logic                          point_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int FW = 2*DAC_W + DWELL_W;

  seq_state_t         state, state_n;
  point_t             pt_q, pt_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [DAC_W-1:0]   value_n;
  logic               axis_n;
  logic               strobe_n;
  logic               done_n;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FW-1:0]      fifo_rd;

  point_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (pt_valid),
    .wr_data ({pt_x, pt_y, dwell}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign pt_ready = !fifo_full;
  assign busy     = (state != ST_IDLE);

  always_comb begin
    state_n  = state;
    pt_n     = pt_q;
    cnt_n    = cnt;
    value_n  = dac_value;
    axis_n   = dac_axis;
    strobe_n = 1'b0;
    pop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          pop     = 1'b1;
          pt_n    = point_t'(fifo_rd[DWELL_W +: 2*DAC_W]);
          cnt_n   = fifo_rd[DWELL_W-1:0];
          state_n = ST_SEND_X;
        end
      end
      ST_SEND_X: begin
        if (dac_ready) begin
          value_n  = pt_q.x;
          axis_n   = 1'b0;
          strobe_n = 1'b1;
          state_n  = ST_HOLD_X;
        end
      end
      ST_HOLD_X: state_n = ST_SEND_Y;
      ST_SEND_Y: begin
        if (dac_ready) begin
          value_n  = pt_q.y;
          axis_n   = 1'b1;
          strobe_n = 1'b1;
          state_n  = ST_HOLD_Y;
        end
      end
      ST_HOLD_Y: state_n = ST_DWELL;
      ST_DWELL: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    // Registered so the pulse lands in the DWELL cycle whose count is zero.
    done_n = (state_n == ST_DWELL) && (cnt_n == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      pt_q       <= '0;
      cnt        <= '0;
      dac_value  <= '0;
      dac_axis   <= 1'b0;
      dac_strobe <= 1'b0;
      point_done <= 1'b0;
    end else begin
      state      <= state_n;
      pt_q       <= pt_n;
      cnt        <= cnt_n;
      dac_value  <= value_n;
      dac_axis   <= axis_n;
      dac_strobe <= strobe_n;
      point_done <= done_n;
    end
  end

endmodule
